// File: rtl/memwb_skid_stage_pkg.sv
// Shared definitions for the MEM->WB skid stage: write-back control bit
// positions, default widths and the packed payload layout.
package memwb_skid_stage_pkg;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int DEF_WB_W   = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_RD_W-1:0]   rd;
  } memwb_payload_t;

  // Width of the {wb, addr, data, rd} concatenation carried by the buffer.
  function automatic int payload_w(input int wb_w, input int addr_w,
                                   input int data_w, input int rd_w);
    return wb_w + addr_w + data_w + rd_w;
  endfunction

endpackage

// File: rtl/memwb_skid_stage_if.sv
// MEM->WB beat bus: one interface instance per side of the stage.
// Handshake: a beat moves on a rising clock edge where valid & ready are both 1;
// valid and payload are held stable by the master until that edge.
interface memwb_skid_stage_if
  import memwb_skid_stage_pkg::*;
#(
  parameter int WB_W   = DEF_WB_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) ();

  logic              valid;
  logic              ready;
  logic [WB_W-1:0]   wb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [RD_W-1:0]   rd;

  modport master (output valid, output wb, output addr, output data, output rd,
                  input ready);
  modport slave  (input valid, input wb, input addr, input data, input rd,
                  output ready);

endinterface

// File: rtl/memwb_skid_stage_skid_buf.sv
// Generic two-entry skid buffer: a main output register plus one skid slot.
// Upstream ready comes straight from a flop, so no input-to-ready path exists.
module memwb_skid_stage_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_xfer_in;

  assign o_ready   = ~r_skid_valid;
  assign o_valid   = r_main_valid;
  assign o_data    = r_main_data;
  assign w_xfer_in = i_valid & ~r_skid_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush_i) begin
      // Payload registers keep stale contents; only the valid bits matter.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (~r_main_valid | i_ready) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        if (w_xfer_in) r_skid_data  <= i_data;
        else           r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_xfer_in;
        if (w_xfer_in) r_main_data <= i_data;
      end
    end else if (w_xfer_in) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM->WB pipeline register: skid-buffered beat path, gated write-back
// forwarding port and a saturating downstream stall counter.
module memwb_skid_stage
  import memwb_skid_stage_pkg::*;
#(
  parameter int WB_W   = DEF_WB_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  memwb_skid_stage_if.slave  up_if,
  memwb_skid_stage_if.master dn_if,
  output logic               fwd_en_o,
  output logic [RD_W-1:0]    fwd_rd_o,
  output logic [DATA_W-1:0]  fwd_data_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int PW = payload_w(WB_W, ADDR_W, DATA_W, RD_W);

  logic [PW-1:0]     w_in;
  logic [PW-1:0]     w_out;
  logic              w_out_valid;
  logic [WB_W-1:0]   w_wb;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [RD_W-1:0]   w_rd;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in = {up_if.wb, up_if.addr, up_if.data, up_if.rd};

  memwb_skid_stage_skid_buf #(.WIDTH(PW)) u_skid_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .i_valid (up_if.valid),
    .o_ready (up_if.ready),
    .i_data  (w_in),
    .o_valid (w_out_valid),
    .i_ready (dn_if.ready),
    .o_data  (w_out)
  );

  assign {w_wb, w_addr, w_data, w_rd} = w_out;

  // Control is masked so a stale register never triggers a write-back.
  assign dn_if.valid = w_out_valid;
  assign dn_if.wb    = w_out_valid ? w_wb : '0;
  assign dn_if.addr  = w_addr;
  assign dn_if.data  = w_data;
  assign dn_if.rd    = w_rd;

  assign fwd_en_o   = w_out_valid & w_wb[WB_REGWRITE] & (w_rd != '0);
  assign fwd_rd_o   = w_rd;
  assign fwd_data_o = w_wb[WB_MEMTOREG] ? w_data : w_addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid & ~dn_if.ready & (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage: reset, streaming, back-pressure,
// flush, forwarding and stall-counter saturation (CNT_W = 3).
module tb_memwb_skid_stage;

  localparam int WB_W = 2, ADDR_W = 32, DATA_W = 32, RD_W = 5, CNT_W = 3;

  logic clk_i;
  logic rst_i;
  logic flush_i;
  logic              fwd_en_o;
  logic [RD_W-1:0]   fwd_rd_o;
  logic [DATA_W-1:0] fwd_data_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  int checks;
  int errors;
  logic [RD_W-1:0] exp_q[$];

  memwb_skid_stage_if #(.WB_W(WB_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W)) up_if ();
  memwb_skid_stage_if #(.WB_W(WB_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W)) dn_if ();

  memwb_skid_stage #(.WB_W(WB_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .up_if       (up_if),
    .dn_if       (dn_if),
    .fwd_en_o    (fwd_en_o),
    .fwd_rd_o    (fwd_rd_o),
    .fwd_data_o  (fwd_data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_beat(input logic v, input logic [WB_W-1:0] wb,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input logic [RD_W-1:0] rd);
    up_if.valid = v;
    up_if.wb    = wb;
    up_if.addr  = addr;
    up_if.data  = data;
    up_if.rd    = rd;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    flush_i = 1'b0;
    dn_if.ready = 1'b1;
    drive_beat(1'b0, '0, '0, '0, '0);
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    dn_if.ready = 1'b0;
    drive_beat(1'b1, 2'b10, 32'h100, 32'h200, 5'd1);
    tick();
    drive_beat(1'b1, 2'b10, 32'h300, 32'h400, 5'd2);
    tick();
    drive_beat(1'b0, '0, '0, '0, '0);
    checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b exp 1", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL rst_pre_ready got %0b exp 0", up_if.ready); end
    checks++; if (stall_cnt_o !== 3'd1) begin errors++; $display("FAIL rst_pre_stall got %0d exp 1", stall_cnt_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", dn_if.valid); end
    checks++; if (dn_if.wb !== 2'b00) begin errors++; $display("FAIL rst_wb got %0b exp 0", dn_if.wb); end
    checks++; if (stall_cnt_o !== 3'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_cnt_o); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", up_if.ready); end
    checks++; if (fwd_en_o !== 1'b0) begin errors++; $display("FAIL rst_fwd_en got %0b exp 0", fwd_en_o); end
    #1;
    rst_i = 1'b1;
    dn_if.ready = 1'b1;
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL rst_post_valid got %0b exp 0", dn_if.valid); end
  endtask

  task automatic test_streaming();
    logic [RD_W-1:0] exp_rd;
    do_reset();
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_beat(1'b1, 2'b10, 32'(i * 16), 32'(i * 256), 5'(i));
      if (up_if.ready === 1'b1) exp_q.push_back(5'(i));
      tick();
      checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat %0d got %0b exp 1", i, dn_if.valid); end
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      checks++; if (dn_if.rd !== exp_rd) begin errors++; $display("FAIL stream_rd got %0d exp %0d", dn_if.rd, exp_rd); end
      checks++; if (dn_if.addr !== 32'(i * 16)) begin errors++; $display("FAIL stream_addr got %0h exp %0h", dn_if.addr, i * 16); end
      checks++; if (stall_cnt_o !== 3'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", stall_cnt_o); end
    end
    drive_beat(1'b0, '0, '0, '0, '0);
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b exp 0", dn_if.valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_queue got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dn_if.ready = 1'b1;
    drive_beat(1'b1, 2'b10, 32'hA0, 32'hA1, 5'd10);
    tick();
    checks++; if (dn_if.rd !== 5'd10) begin errors++; $display("FAIL bp_a_first got %0d exp 10", dn_if.rd); end
    dn_if.ready = 1'b0;
    drive_beat(1'b1, 2'b10, 32'hB0, 32'hB1, 5'd11);
    tick();
    checks++; if (dn_if.rd !== 5'd10 || dn_if.valid !== 1'b1) begin errors++; $display("FAIL bp_a_hold got %0d exp 10", dn_if.rd); end
    checks++; if (up_if.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %0b exp 0", up_if.ready); end
    drive_beat(1'b1, 2'b10, 32'hC0, 32'hC1, 5'd12);
    tick();
    checks++; if (dn_if.rd !== 5'd10) begin errors++; $display("FAIL bp_a_hold2 got %0d exp 10", dn_if.rd); end
    checks++; if (stall_cnt_o !== 3'd2) begin errors++; $display("FAIL bp_stall got %0d exp 2", stall_cnt_o); end
    dn_if.ready = 1'b1;
    tick();
    checks++; if (dn_if.rd !== 5'd11 || dn_if.addr !== 32'hB0) begin errors++; $display("FAIL bp_b got %0d exp 11", dn_if.rd); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL bp_ready_high got %0b exp 1", up_if.ready); end
    tick();
    drive_beat(1'b0, '0, '0, '0, '0);
    checks++; if (dn_if.rd !== 5'd12 || dn_if.valid !== 1'b1) begin errors++; $display("FAIL bp_c got %0d exp 12", dn_if.rd); end
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", dn_if.valid); end
    checks++; if (stall_cnt_o !== 3'd2) begin errors++; $display("FAIL bp_stall_hold got %0d exp 2", stall_cnt_o); end
  endtask

  task automatic test_flush();
    do_reset();
    dn_if.ready = 1'b0;
    drive_beat(1'b1, 2'b10, 32'h10, 32'h11, 5'd3);
    tick();
    drive_beat(1'b1, 2'b10, 32'h20, 32'h21, 5'd4);
    tick();
    flush_i = 1'b1;
    drive_beat(1'b1, 2'b10, 32'hD0, 32'hD1, 5'd13);
    tick();
    flush_i = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0);
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", dn_if.valid); end
    checks++; if (up_if.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", up_if.ready); end
    checks++; if (fwd_en_o !== 1'b0) begin errors++; $display("FAIL flush_fwd_en got %0b exp 0", fwd_en_o); end
    checks++; if (stall_cnt_o !== 3'd2) begin errors++; $display("FAIL flush_stall_kept got %0d exp 2", stall_cnt_o); end
    dn_if.ready = 1'b1;
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %0b exp 0", dn_if.valid); end
    drive_beat(1'b1, 2'b10, 32'hE0, 32'hE1, 5'd14);
    tick();
    dn_if.ready = 1'b0;
    flush_i = 1'b1;
    drive_beat(1'b1, 2'b10, 32'hF0, 32'hF1, 5'd15);
    tick();
    flush_i = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0);
    dn_if.ready = 1'b1;
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush2_valid got %0b exp 0", dn_if.valid); end
    tick();
    checks++; if (dn_if.valid !== 1'b0) begin errors++; $display("FAIL flush2_dropped got %0b exp 0", dn_if.valid); end
  endtask

  task automatic test_forwarding();
    do_reset();
    dn_if.ready = 1'b1;
    drive_beat(1'b1, 2'b10, 32'h1234, 32'h5555, 5'd7);
    tick();
    checks++; if (fwd_en_o !== 1'b1) begin errors++; $display("FAIL fwd_alu_en got %0b exp 1", fwd_en_o); end
    checks++; if (fwd_data_o !== 32'h1234) begin errors++; $display("FAIL fwd_alu_data got %0h exp 1234", fwd_data_o); end
    checks++; if (fwd_rd_o !== 5'd7) begin errors++; $display("FAIL fwd_rd got %0d exp 7", fwd_rd_o); end
    checks++; if (dn_if.wb !== 2'b10) begin errors++; $display("FAIL fwd_wb got %0b exp 10", dn_if.wb); end
    drive_beat(1'b1, 2'b11, 32'h1111, 32'hBEEF, 5'd3);
    tick();
    checks++; if (fwd_data_o !== 32'hBEEF) begin errors++; $display("FAIL fwd_mem_data got %0h exp beef", fwd_data_o); end
    checks++; if (fwd_en_o !== 1'b1) begin errors++; $display("FAIL fwd_mem_en got %0b exp 1", fwd_en_o); end
    drive_beat(1'b1, 2'b10, 32'h9, 32'h8, 5'd0);
    tick();
    checks++; if (fwd_en_o !== 1'b0) begin errors++; $display("FAIL fwd_rd0_en got %0b exp 0", fwd_en_o); end
    drive_beat(1'b1, 2'b01, 32'h77, 32'h66, 5'd5);
    tick();
    checks++; if (fwd_en_o !== 1'b0) begin errors++; $display("FAIL fwd_noregw_en got %0b exp 0", fwd_en_o); end
    checks++; if (fwd_data_o !== 32'h66) begin errors++; $display("FAIL fwd_noregw_data got %0h exp 66", fwd_data_o); end
    drive_beat(1'b0, '0, '0, '0, '0);
    tick();
    checks++; if (dn_if.wb !== 2'b00) begin errors++; $display("FAIL fwd_idle_wb got %0b exp 0", dn_if.wb); end
  endtask

  task automatic test_counter_saturation();
    int exp_cnt;
    do_reset();
    dn_if.ready = 1'b0;
    drive_beat(1'b1, 2'b10, 32'h40, 32'h41, 5'd9);
    tick();
    drive_beat(1'b0, '0, '0, '0, '0);
    checks++; if (stall_cnt_o !== 3'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", stall_cnt_o); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_cnt = (i > 7) ? 7 : i;
      checks++; if (stall_cnt_o !== 3'(exp_cnt)) begin errors++; $display("FAIL sat_step %0d got %0d exp %0d", i, stall_cnt_o, exp_cnt); end
    end
    checks++; if (dn_if.valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0b exp 1", dn_if.valid); end
    dn_if.ready = 1'b1;
    tick();
    checks++; if (stall_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", stall_cnt_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i = 1'b0;
    flush_i = 1'b0;
    dn_if.ready = 1'b1;
    drive_beat(1'b0, '0, '0, '0, '0);
    test_reset();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_forwarding();
    test_counter_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
